// File: rtl/core_output_arbiter_if.sv
// Sender-side bundle of the core output arbiter: one pending request
// (valid/mode/data) toward the UART sender, its ready, and the drop count.
interface core_output_arbiter_if #(
  parameter int P_SEL_W  = 2,
  parameter int P_DATA_W = 32
);
  logic                oSenderValid;
  logic                iSenderReady;
  logic [P_SEL_W-1:0]  oSenderMode;
  logic [P_DATA_W-1:0] oSenderData;
  logic [7:0]          oDropCnt;

  // Arbiter side: owns the request, observes ready.
  modport master (
    output oSenderValid, oSenderMode, oSenderData, oDropCnt,
    input  iSenderReady
  );

  // Sender side: observes the request, drives ready.
  modport slave (
    input  oSenderValid, oSenderMode, oSenderData, oDropCnt,
    output iSenderReady
  );
endinterface

// File: rtl/core_output_arbiter.sv
// core_output_arbiter: registered selector between the core channels and the
// FND/display path plus the UART sender. Adds timed blanking on a mode switch,
// a one-entry sender hold register with a saturating drop counter, periodic
// sender requests for free-running channels and stale detection for
// event-driven channels.
module core_output_arbiter #(
  parameter int                  P_NUM_CH        = 4,
  parameter int                  P_SEL_W         = 2,
  parameter int                  P_DATA_W        = 32,
  parameter int                  P_BLANK_MS      = 100,
  parameter int                  P_PERIOD_MS     = 1000,
  parameter logic [P_NUM_CH-1:0] P_PERIODIC_MASK = 'b0011,
  parameter int                  P_STALE_MS      = 3000
) (
  input  logic                         iClk,
  input  logic                         iRstn,
  input  logic                         iTick1kHz,
  input  logic [P_SEL_W-1:0]           iMode,
  input  logic [16*P_NUM_CH-1:0]       iFndFlat,
  input  logic [P_DATA_W*P_NUM_CH-1:0] iFullFlat,
  input  logic [4*P_NUM_CH-1:0]        iBlinkFlat,
  input  logic [4*P_NUM_CH-1:0]        iDotFlat,
  input  logic [P_NUM_CH-1:0]          iValidVec,
  output logic [15:0]                  oFndData,
  output logic [P_DATA_W-1:0]          oFullData,
  output logic [3:0]                   oBlinkMask,
  output logic [3:0]                   oDotMask,
  output logic [P_SEL_W-1:0]           oActiveMode,
  output logic                         oSwitching,
  output logic                         oStale,
  core_output_arbiter_if.master        sender
);

  // Every select code gets a slot; codes at or above P_NUM_CH read as zero
  // and are flagged illegal, so indexing by any select value stays in range.
  localparam int L_SLOTS = 2 ** P_SEL_W;

  localparam int L_BLK_W = $clog2(P_BLANK_MS + 2);
  localparam int L_PER_W = $clog2(P_PERIOD_MS + 1);
  localparam int L_STL_W = $clog2(P_STALE_MS + 1);

  localparam logic [L_BLK_W-1:0] L_BLK_LAST = L_BLK_W'(P_BLANK_MS - 1);
  localparam logic [L_PER_W-1:0] L_PER_LAST = L_PER_W'(P_PERIOD_MS - 1);
  localparam logic [L_STL_W-1:0] L_STL_MAX  = L_STL_W'(P_STALE_MS);

  typedef enum logic {ST_RUN = 1'b0, ST_BLANK = 1'b1} state_t;

  // Unpacked per-channel views of the flat input buses.
  logic [15:0]         fnd_ch   [L_SLOTS];
  logic [P_DATA_W-1:0] full_ch  [L_SLOTS];
  logic [3:0]          blink_ch [L_SLOTS];
  logic [3:0]          dot_ch   [L_SLOTS];
  logic [L_SLOTS-1:0]  valid_ch;
  logic [L_SLOTS-1:0]  legal_ch;
  logic [L_SLOTS-1:0]  periodic_ch;

  genvar gi;
  generate
    for (gi = 0; gi < L_SLOTS; gi++) begin : g_ch
      if (gi < P_NUM_CH) begin : g_real
        assign fnd_ch[gi]      = iFndFlat[16*gi +: 16];
        assign full_ch[gi]     = iFullFlat[P_DATA_W*gi +: P_DATA_W];
        assign blink_ch[gi]    = iBlinkFlat[4*gi +: 4];
        assign dot_ch[gi]      = iDotFlat[4*gi +: 4];
        assign valid_ch[gi]    = iValidVec[gi];
        assign legal_ch[gi]    = 1'b1;
        assign periodic_ch[gi] = P_PERIODIC_MASK[gi];
      end else begin : g_pad
        assign fnd_ch[gi]      = '0;
        assign full_ch[gi]     = '0;
        assign blink_ch[gi]    = '0;
        assign dot_ch[gi]      = '0;
        assign valid_ch[gi]    = 1'b0;
        assign legal_ch[gi]    = 1'b0;
        assign periodic_ch[gi] = 1'b0;
      end
    end
  endgenerate

  state_t              state_q, state_d;
  logic [P_SEL_W-1:0]  active_q, active_d;
  logic [P_SEL_W-1:0]  target_q, target_d;
  logic [L_BLK_W-1:0]  blank_cnt_q, blank_cnt_d;
  logic [L_PER_W-1:0]  period_cnt_q, period_cnt_d;
  logic [L_STL_W-1:0]  stale_cnt_q, stale_cnt_d;
  logic                stale_q, stale_d;
  logic [15:0]         fnd_q, fnd_d;
  logic [P_DATA_W-1:0] full_q, full_d;
  logic [3:0]          blink_q, blink_d;
  logic [3:0]          dot_q, dot_d;
  logic                snd_valid_q, snd_valid_d;
  logic [P_SEL_W-1:0]  snd_mode_q, snd_mode_d;
  logic [P_DATA_W-1:0] snd_data_q, snd_data_d;
  logic [7:0]          drop_q, drop_d;

  logic req;
  logic accept;
  logic mode_legal;

  assign mode_legal = legal_ch[iMode];
  assign accept     = snd_valid_q & sender.iSenderReady;

  // Next-state: mode FSM, display mux, request sources, hold register, stale.
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    target_d     = target_q;
    blank_cnt_d  = blank_cnt_q;
    period_cnt_d = period_cnt_q;
    stale_cnt_d  = stale_cnt_q;
    fnd_d        = '0;
    full_d       = '0;
    blink_d      = '0;
    dot_d        = '0;
    snd_valid_d  = snd_valid_q;
    snd_mode_d   = snd_mode_q;
    snd_data_d   = snd_data_q;
    drop_d       = drop_q;
    req          = 1'b0;

    case (state_q)
      ST_RUN: begin
        fnd_d   = fnd_ch[active_q];
        full_d  = full_ch[active_q];
        blink_d = blink_ch[active_q];
        dot_d   = dot_ch[active_q];

        // Requests always come from the mode that is active now, even when
        // a mode change is requested in the same cycle.
        if (periodic_ch[active_q]) begin
          if (iTick1kHz) begin
            if (period_cnt_q == L_PER_LAST) begin
              req          = 1'b1;
              period_cnt_d = '0;
            end else begin
              period_cnt_d = period_cnt_q + L_PER_W'(1);
            end
          end
        end else begin
          req = valid_ch[active_q];
        end

        // A fresh sample beats a simultaneous tick.
        if (valid_ch[active_q]) begin
          stale_cnt_d = '0;
        end else if (iTick1kHz && (stale_cnt_q != L_STL_MAX)) begin
          stale_cnt_d = stale_cnt_q + L_STL_W'(1);
        end

        if (mode_legal && (iMode != active_q)) begin
          target_d = iMode;
          if (P_BLANK_MS == 0) begin
            active_d     = iMode;
            period_cnt_d = '0;
            stale_cnt_d  = '0;
          end else begin
            state_d     = ST_BLANK;
            blank_cnt_d = '0;
            fnd_d       = '0;
            full_d      = '0;
            blink_d     = '0;
            dot_d       = '0;
          end
        end
      end

      ST_BLANK: begin
        // A different target restarts the full blank interval; a request
        // back to the original mode is just another target.
        if (mode_legal && (iMode != target_q)) begin
          target_d    = iMode;
          blank_cnt_d = '0;
        end else if (iTick1kHz) begin
          if (blank_cnt_q == L_BLK_LAST) begin
            state_d      = ST_RUN;
            active_d     = target_q;
            blank_cnt_d  = '0;
            period_cnt_d = '0;
            stale_cnt_d  = '0;
          end else begin
            blank_cnt_d = blank_cnt_q + L_BLK_W'(1);
          end
        end
      end

      default: state_d = ST_RUN;
    endcase

    // One-entry hold: a request loads when idle or when the pending entry
    // leaves this cycle; otherwise it is counted as dropped.
    if (req) begin
      if (!snd_valid_q || accept) begin
        snd_valid_d = 1'b1;
        snd_mode_d  = active_q;
        snd_data_d  = full_ch[active_q];
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (accept) begin
      snd_valid_d = 1'b0;
    end

    stale_d = (state_d == ST_RUN) && !periodic_ch[active_d] &&
              (stale_cnt_d >= L_STL_MAX);
  end

  // State and all registered outputs.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q      <= ST_RUN;
      active_q     <= '0;
      target_q     <= '0;
      blank_cnt_q  <= '0;
      period_cnt_q <= '0;
      stale_cnt_q  <= '0;
      stale_q      <= 1'b0;
      fnd_q        <= '0;
      full_q       <= '0;
      blink_q      <= '0;
      dot_q        <= '0;
      snd_valid_q  <= 1'b0;
      snd_mode_q   <= '0;
      snd_data_q   <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      target_q     <= target_d;
      blank_cnt_q  <= blank_cnt_d;
      period_cnt_q <= period_cnt_d;
      stale_cnt_q  <= stale_cnt_d;
      stale_q      <= stale_d;
      fnd_q        <= fnd_d;
      full_q       <= full_d;
      blink_q      <= blink_d;
      dot_q        <= dot_d;
      snd_valid_q  <= snd_valid_d;
      snd_mode_q   <= snd_mode_d;
      snd_data_q   <= snd_data_d;
      drop_q       <= drop_d;
    end
  end

  assign oFndData            = fnd_q;
  assign oFullData           = full_q;
  assign oBlinkMask          = blink_q;
  assign oDotMask            = dot_q;
  assign oActiveMode         = active_q;
  assign oSwitching          = (state_q == ST_BLANK);
  assign oStale              = stale_q;
  assign sender.oSenderValid = snd_valid_q;
  assign sender.oSenderMode  = snd_mode_q;
  assign sender.oSenderData  = snd_data_q;
  assign sender.oDropCnt     = drop_q;

endmodule

// File: doc/core_output_arbiter.md
Name: core_output_arbiter

Overview:
- Parametrised, registered successor to the core-output selector. It takes display and sender bundles from P_NUM_CH cores and drives the FND/display path and the UART sender path.
- Adds four things the combinational selector lacks:
  - timed blanking on mode switch;
  - a valid/ready sender handshake with a one-entry hold register and a drop counter;
  - periodic sender requests for free-running channels;
  - stale-data detection for event-driven sensor channels.
- Sits between the core wrapper and the FND controller / sender.

Parameters:
- P_NUM_CH, 4, number of core channels (2..16).
- P_SEL_W, 2, mode select width; 2**P_SEL_W >= P_NUM_CH.
- P_DATA_W, 32, full/sender data width.
- P_BLANK_MS, 100, blank time on mode switch in 1 kHz ticks; 0 = no blank.
- P_PERIOD_MS, 1000, periodic sender request interval in ticks (>=1).
- P_PERIODIC_MASK, 4'b0011, bit c=1: channel c is periodic (watch/stopwatch); 0: event-driven (sensor).
- P_STALE_MS, 3000, ticks without iValidVec before an event channel is stale (>=1).

Ports:
- iClk  in  1  system clock.
- iRstn  in  1  asynchronous active-low reset.
- iTick1kHz  in  1  one-cycle 1 kHz tick.
- iMode  in  P_SEL_W  requested mode.
- iFndFlat  in  16*P_NUM_CH  per-channel FND BCD; channel c at [16c+15:16c].
- iFullFlat  in  P_DATA_W*P_NUM_CH  per-channel full data.
- iBlinkFlat  in  4*P_NUM_CH  per-channel blink mask.
- iDotFlat  in  4*P_NUM_CH  per-channel dot mask.
- iValidVec  in  P_NUM_CH  per-channel new-sample pulse.
- oFndData  out  16  registered display data.
- oFullData  out  P_DATA_W  registered full data.
- oBlinkMask  out  4  registered blink mask.
- oDotMask  out  4  registered dot mask.
- oActiveMode  out  P_SEL_W  committed mode.
- oSwitching  out  1  high while in ST_BLANK.
- oStale  out  1  active event channel is stale.
- oSenderValid  out  1  sender request pending.
- iSenderReady  in  1  sender accepts when high with oSenderValid.
- oSenderMode  out  P_SEL_W  mode tag of the pending request.
- oSenderData  out  P_DATA_W  data of the pending request.
- oDropCnt  out  8  saturating count of dropped sender requests.

Behaviour:
- Reset (asynchronous, iRstn=0): all outputs 0, ST_RUN, oActiveMode=0, all counters 0.
- Legal mode: iMode < P_NUM_CH. Illegal values are ignored; the state is unchanged.
- ST_RUN:
  - Every cycle, display outputs register channel oActiveMode's fields (1-cycle latency).
  - A legal iMode != oActiveMode latches the target.
  - If P_BLANK_MS=0, commit oActiveMode next cycle and stay in ST_RUN.
  - Otherwise go to ST_BLANK and clear the blank counter.
- ST_BLANK:
  - oSwitching=1; oFndData, oFullData, oBlinkMask, oDotMask forced to 0.
  - The blank counter increments on iTick1kHz.
  - A new legal iMode different from the latched target reloads the target and clears the counter.
  - On the P_BLANK_MS-th tick: commit target to oActiveMode, go to ST_RUN, clear the period and stale counters.
  - Returning to the original mode during blank still completes the blank.
- Sender request sources (ST_RUN only):
  - Event channel: iValidVec[oActiveMode].
  - Periodic channel: the period counter reaching P_PERIOD_MS ticks, then the counter reloads to 0.
  - iValidVec of non-active channels is ignored.
- Hold register:
  - A request while idle (oSenderValid=0) loads oSenderData=iFullFlat[active] and oSenderMode=oActiveMode, sets oSenderValid next cycle (1-cycle latency).
  - Accept is oSenderValid & iSenderReady; oSenderValid clears next cycle unless a new request arrives in the same cycle, in which case it reloads and stays 1 with no drop.
  - A request while busy and not accepting is dropped; oDropCnt +1, saturating at 255.
  - While oSenderValid=1, oSenderData and oSenderMode are stable until accepted, including across mode switches.
  - A pending request is never flushed by a mode switch.
- Stale (event channels only):
  - The stale counter counts ticks since the last active iValidVec and saturates.
  - oStale=1 when the counter >= P_STALE_MS and the active channel is not periodic.
  - iValidVec clears the counter and oStale next cycle.
  - A mode commit clears the counter and oStale.
  - oStale=0 in ST_BLANK.
- Simultaneous tick and iValidVec: the valid wins; the counter goes to 0.
- Simultaneous mode request and sender request in ST_RUN: the sender request is served from the current active mode.

Test Plan:
- Reset mid-operation with oSenderValid=1 and oDropCnt=5 → next cycle all outputs 0, oActiveMode=0.
- Mode 0→2 with P_BLANK_MS=100 → oSwitching=1 and oFndData=0 for exactly 100 ticks, then oActiveMode=2 and oFndData=iFndFlat[47:32] one cycle later.
- Mode 2→3 at tick 40, then 3→1 at tick 60 → blank restarts at 60, commit to 1 at tick 160, no commit to 3.
- Mode 2, iSenderReady=0, three iValidVec[2] pulses → oSenderValid=1 holding the first sample's data, oDropCnt=2; raising ready with a simultaneous valid → new data, oSenderValid stays 1, oDropCnt=2.
- Mode 0 (periodic), P_PERIOD_MS=1000, ready=1 → one oSenderValid pulse every 1000 ticks with oSenderMode=0; oStale stays 0.
- Mode 3, no iValidVec for 3000 ticks → oStale=1; one iValidVec[3] pulse → oStale=0 next cycle; oDropCnt saturates at 255 after 300 drops.
